aes_128_sched: RTL and testbench
================================

# aes_128_sched

Scheduler that shares one AES_128 encryption core between `N_REQ` independent requesters. It accepts plaintext/key jobs over per-requester valid/ready channels and arbitrates between them. It drives the core's `start`/`in`/`key_in`, waits the core's fixed latency and returns the ciphertext on one shared response channel tagged with the requester index. It sits directly in front of AES_128; the core itself is unchanged.

## Interface
- `N_REQ`, 4, number of requesters (≥1)
- `CORE_LAT`, 12, cycles from the `core_start` cycle until `core_out` holds the valid result (≥1)
- `IDW`, `$clog2(N_REQ)` (1 when `N_REQ`=1), requester-id width
- `clk`  in  1  clock
- `rst`  in  1  synchronous reset, active-high
- `req_valid`  in  N_REQ  job offered, one bit per requester
- `req_ready`  out  N_REQ  job accepted (one-hot or zero)
- `req_data`  in  N_REQ*128  plaintext; requester i uses bits [128*i+127:128*i]
- `req_key`  in  N_REQ*128  key, same packing
- `rsp_valid`  out  1  ciphertext available
- `rsp_ready`  in  1  consumer takes response
- `rsp_data`  out  128  ciphertext
- `rsp_id`  out  IDW  index of the requester that owns `rsp_data`
- `core_start`  out  1  one-cycle start pulse to AES_128
- `core_in`  out  128  plaintext to AES_128
- `core_key`  out  128  key to AES_128
- `core_out`  in  128  AES_128 result
- `busy`  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req_valid` bit is set, the arbiter picks grant g. `req_ready[g]`=1 combinationally in that cycle. `req_data`/`req_key` slice g latch into `core_in`/`core_key`, and g latches into `rsp_id`. Next state is ISSUE. If no `req_valid` bit is set, all `req_ready` bits stay 0.
- ISSUE: `core_start`=1 for exactly this cycle. Down-counter loads `CORE_LAT`-1. Next state is WAIT.
- WAIT: counter decrements each cycle. When it reaches 0, `core_out` is registered into `rsp_data` and the next state is RESP. If `CORE_LAT`=1, the capture happens in the first WAIT cycle.
- RESP: `rsp_valid`=1. `rsp_data`/`rsp_id` are held stable until `rsp_ready`=1, and on that cycle the next state is IDLE.
- `core_in`/`core_key` change only on an accept. They stay stable from ISSUE through RESP. Requester inputs that change after acceptance have no effect.
- No new job is accepted until the current response handshakes, so only one job is in flight.
- `req_ready` is 0 in every state other than IDLE.
- Reset in any state: the FSM goes to IDLE and the in-flight job is dropped with no response. The core's late result is ignored.

## Timing
- Reset values: `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_id`=0, `core_start`=0, `core_in`=0, `core_key`=0, `busy`=0, round-robin pointer=0, counter=0.
- Accept at cycle T:
  - `core_start` high at T+1.
  - `core_out` captured at T+1+`CORE_LAT`.
  - `rsp_valid` first high at T+2+`CORE_LAT`.
- With `rsp_ready` tied high, jobs are accepted every `CORE_LAT`+3 cycles.
- `busy` rises at T+1 and falls the cycle after the response handshake.

## Configuration
- `AES_SCHED_RR_EN` defined:
  - Round-robin arbitration. The search starts at the pointer and wraps modulo `N_REQ`.
  - On accept, the pointer becomes (g+1) mod `N_REQ`.
- `AES_SCHED_RR_EN` not defined:
  - Fixed priority: the lowest asserted index wins.
  - The pointer register is removed.

## Structure
- Shared package `aes_pkg`: `AES_BLK_W`=128 and the FSM state enum (IDLE/ISSUE/WAIT/RESP).
- Sub-module `aes_sched_arb`: combinational grant from `req_valid` plus the pointer register. It is compiled for round-robin or fixed priority by `AES_SCHED_RR_EN`.
- The FSM, counter and datapath registers stay in the top module.

## Test plan
All scenarios use the real AES_128 core (or a `CORE_LAT` model) with the FIPS-197 vector: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734.
- Single job on requester 2, `rsp_ready`=1 → `req_ready`=4'b0100 for one cycle. `core_start` pulses once at T+1. At T+14, `rsp_valid`=1, `rsp_data`=3925841d02dc09fbdc118597196a0b32 and `rsp_id`=2.
- All four `req_valid` held high:
  - With `AES_SCHED_RR_EN`, grants go 0,1,2,3,0.
  - Without it, requester 0 is granted every time.
  - In both cases accepts are 15 cycles apart.
- `rsp_ready` held low for 20 cycles in RESP → `rsp_valid`/`rsp_data`/`rsp_id` stay stable, `req_ready`=0 and `core_start`=0 throughout. Release → IDLE on the next cycle.
- `req_data`/`req_key` changed to all-ones right after accept → `core_in`/`core_key` unchanged and the response is still 3925841d….
- `rst` asserted for one cycle in WAIT → all outputs are at reset values the next cycle and no `rsp_valid` follows. A fresh job afterwards completes normally.
- `N_REQ`=1, `CORE_LAT`=1 build → accept, start at T+1, `rsp_valid` at T+3 with the model's output.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 core scheduler: block width, FSM state
// encoding and a helper for requester-id width.
package aes_pkg;

  localparam int unsigned AES_BLK_W = 128;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } sched_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/aes_sched_arb.sv
// Grant selection for the AES-128 scheduler.
// AES_SCHED_RR_EN defined: round-robin search starting at a pointer that moves
// past each accepted requester. Undefined: fixed priority, lowest index wins,
// and no pointer register exists.
module aes_sched_arb #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned IDW   = 2
) (
`ifdef AES_SCHED_RR_EN
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
`endif
  input  logic [N_REQ-1:0] req_valid,
  output logic             grant_valid,
  output logic [IDW-1:0]   grant_id,
  output logic [N_REQ-1:0] grant_onehot
);

  logic [IDW-1:0] search_base;

`ifdef AES_SCHED_RR_EN
  logic [IDW-1:0] ptr_q;

  assign search_base = ptr_q;

  // Pointer moves to the requester after the one just accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= IDW'((32'(grant_id) + 32'd1) % N_REQ);
    end
  end
`else
  assign search_base = '0;
`endif

  // First asserted request found walking upward from search_base, wrapping.
  always_comb begin
    int unsigned      idx;
    logic [N_REQ-1:0] shifted;
    grant_valid  = 1'b0;
    grant_id     = '0;
    grant_onehot = '0;
    idx          = 0;
    shifted      = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      idx     = (32'(search_base) + i) % N_REQ;
      shifted = req_valid >> idx;
      if (!grant_valid && shifted[0]) begin
        grant_valid  = 1'b1;
        grant_id     = IDW'(idx);
        grant_onehot = N_REQ'(1) << idx;
      end
    end
  end

endmodule

// File: rtl/aes_128_sched.sv
// Shares one AES-128 core between N_REQ requesters. One job in flight at a
// time: accept, pulse core start, wait the fixed core latency, capture the
// result and hold it on the response channel until taken.
// Arbitration mode is selected by the AES_SCHED_RR_EN macro (see aes_sched_arb).
module aes_128_sched
  import aes_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned CORE_LAT = 12,
  parameter int unsigned IDW      = id_width(N_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*AES_BLK_W-1:0] req_data,
  input  logic [N_REQ*AES_BLK_W-1:0] req_key,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [AES_BLK_W-1:0]     rsp_data,
  output logic [IDW-1:0]           rsp_id,
  output logic                     core_start,
  output logic [AES_BLK_W-1:0]     core_in,
  output logic [AES_BLK_W-1:0]     core_key,
  input  logic [AES_BLK_W-1:0]     core_out,
  output logic                     busy
);

  localparam int unsigned CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

  sched_state_e         state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [AES_BLK_W-1:0] core_in_q;
  logic [AES_BLK_W-1:0] core_key_q;
  logic [AES_BLK_W-1:0] rsp_data_q;
  logic [IDW-1:0]       rsp_id_q;
  logic                 rsp_valid_q;
  logic                 core_start_q;
  logic                 busy_q;

  logic                 grant_valid;
  logic [IDW-1:0]       grant_id;
  logic [N_REQ-1:0]     grant_onehot;
  logic [AES_BLK_W-1:0] sel_data;
  logic [AES_BLK_W-1:0] sel_key;

`ifdef AES_SCHED_RR_EN
  logic accept;
  assign accept = (state_q == StIdle) && grant_valid;
`endif

  aes_sched_arb #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
`ifdef AES_SCHED_RR_EN
    .clk          (clk),
    .rst          (rst),
    .accept       (accept),
`endif
    .req_valid    (req_valid),
    .grant_valid  (grant_valid),
    .grant_id     (grant_id),
    .grant_onehot (grant_onehot)
  );

  // Route the granted requester's plaintext and key toward the core registers.
  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_onehot[i]) begin
        sel_data = sel_data | req_data[AES_BLK_W*i +: AES_BLK_W];
        sel_key  = sel_key  | req_key[AES_BLK_W*i +: AES_BLK_W];
      end
    end
  end

  // Accept handshake only in IDLE; held low while reset is asserted.
  assign req_ready = ((state_q == StIdle) && !rst) ? grant_onehot : '0;

  // Job sequencing FSM with registered datapath and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      core_in_q    <= '0;
      core_key_q   <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      rsp_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      core_start_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_valid) begin
            core_in_q    <= sel_data;
            core_key_q   <= sel_key;
            rsp_id_q     <= grant_id;
            core_start_q <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= StIssue;
          end
        end
        StIssue: begin
          cnt_q   <= CNT_W'(CORE_LAT - 1);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == '0) begin
            rsp_data_q  <= core_out;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign core_start = core_start_q;
  assign core_in    = core_in_q;
  assign core_key   = core_key_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aes_128_sched.sv
// Bench for aes_128_sched: a job-level reference model predicts every output
// each cycle; directed scenarios plus a random phase, and a second instance
// built with one requester and unit core latency.
module tb_aes_128_sched;

  localparam int N   = 4;
  localparam int L   = 12;
  localparam int IDW = 2;

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] JUNK     = {4{32'hdeadbeef}};

  logic             clk;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_data;
  logic [N*128-1:0] req_key;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [127:0]     rsp_data;
  logic [IDW-1:0]   rsp_id;
  logic             core_start;
  logic [127:0]     core_in;
  logic [127:0]     core_key;
  logic [127:0]     core_out;
  logic             busy;

  logic         rst1;
  logic [0:0]   req_valid1;
  logic [0:0]   req_ready1;
  logic [127:0] req_data1;
  logic [127:0] req_key1;
  logic         rsp_valid1;
  logic         rsp_ready1;
  logic [127:0] rsp_data1;
  logic [0:0]   rsp_id1;
  logic         core_start1;
  logic [127:0] core_in1;
  logic [127:0] core_key1;
  logic [127:0] core_out1;
  logic         busy1;

  aes_128_sched #(.N_REQ(N), .CORE_LAT(L)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_data   (req_data),
    .req_key    (req_key),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .core_start (core_start),
    .core_in    (core_in),
    .core_key   (core_key),
    .core_out   (core_out),
    .busy       (busy)
  );

  aes_128_sched #(.N_REQ(1), .CORE_LAT(1)) u_dut1 (
    .clk        (clk),
    .rst        (rst1),
    .req_valid  (req_valid1),
    .req_ready  (req_ready1),
    .req_data   (req_data1),
    .req_key    (req_key1),
    .rsp_valid  (rsp_valid1),
    .rsp_ready  (rsp_ready1),
    .rsp_data   (rsp_data1),
    .rsp_id     (rsp_id1),
    .core_start (core_start1),
    .core_in    (core_in1),
    .core_key   (core_key1),
    .core_out   (core_out1),
    .busy       (busy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for AES_128: exact on the FIPS-197 vector, a keyed mix otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[95:0], key[127:96]} ^ 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
  endfunction

  // Core models: result valid only in the cycle CORE_LAT after the start pulse.
  logic [127:0] c_pt, c_key, c1_pt, c1_key;
  int           c_cnt, c1_cnt;
  bit           c_arm, c1_arm;

  always @(posedge clk) begin
    if (core_start) begin
      c_pt <= core_in; c_key <= core_key; c_cnt <= L - 1; c_arm <= 1'b1;
    end else if (c_arm) begin
      if (c_cnt == 0) c_arm <= 1'b0;
      else c_cnt <= c_cnt - 1;
    end
  end
  assign core_out = (c_arm && c_cnt == 0) ? core_fn(c_pt, c_key) : JUNK;

  always @(posedge clk) begin
    if (core_start1) begin
      c1_pt <= core_in1; c1_key <= core_key1; c1_cnt <= 0; c1_arm <= 1'b1;
    end else if (c1_arm) begin
      c1_arm <= 1'b0;
    end
  end
  assign core_out1 = c1_arm ? core_fn(c1_pt, c1_key) : JUNK;

  int n_err = 0;
  int n_chk = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Job-level reference model.
  bit           m_busy = 1'b0;
  int           m_t    = 0;
  int           m_acc  = 0;
  int           m_ptr  = 0;
  int           m_id   = 0;
  logic [127:0] m_in   = '0;
  logic [127:0] m_key  = '0;
  logic [127:0] m_rsp  = '0;
  logic [127:0] m_res  = '0;

  int           obs_ids[$];
  int           obs_ts[$];
  int           hs_cnt = 0;
  int           hs_t   = 0;
  logic [127:0] hs_data = '0;
  int           hs_id  = 0;

  function automatic int pick(input logic [N-1:0] v);
`ifdef AES_SCHED_RR_EN
    for (int i = 0; i < N; i++) begin
      int k = (m_ptr + i) % N;
      if (v[k]) return k;
    end
`else
    for (int i = 0; i < N; i++) if (v[i]) return i;
`endif
    return -1;
  endfunction

  // Check every output for the current cycle against the model, then advance.
  task automatic cycle();
    logic [N-1:0] exp_ready;
    bit           exp_rv;
    int           g;
    #1;
    if (m_busy && m_t == m_acc + 2 + L) m_rsp = m_res;
    exp_rv    = m_busy && (m_t >= m_acc + 2 + L);
    g         = pick(req_valid);
    exp_ready = (!m_busy && g >= 0) ? (N'(1) << g) : '0;
    if (!rst) check_eq("req_ready", req_ready, exp_ready);
    check_eq("core_start", core_start, m_busy && (m_t == m_acc + 1));
    check_eq("rsp_valid", rsp_valid, exp_rv);
    check_eq("busy", busy, m_busy);
    check_eq("core_in", core_in, m_in);
    check_eq("core_key", core_key, m_key);
    check_eq("rsp_data", rsp_data, m_rsp);
    check_eq("rsp_id", rsp_id, m_id);
    if (!rst && req_ready != '0) begin
      for (int i = 0; i < N; i++) if (req_ready[i]) obs_ids.push_back(i);
      obs_ts.push_back(m_t);
    end
    if (!rst && rsp_valid && rsp_ready) begin
      hs_cnt++; hs_data = rsp_data; hs_id = int'(rsp_id); hs_t = m_t;
    end
    if (rst) begin
      m_busy = 1'b0; m_ptr = 0; m_id = 0; m_in = '0; m_key = '0; m_rsp = '0;
    end else if (exp_rv) begin
      if (rsp_ready) m_busy = 1'b0;
    end else if (!m_busy && g >= 0) begin
      m_busy = 1'b1;
      m_acc  = m_t;
      m_id   = g;
      m_in   = req_data[128*g +: 128];
      m_key  = req_key[128*g +: 128];
      m_res  = core_fn(m_in, m_key);
      m_ptr  = (g + 1) % N;
    end
    m_t++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_slot(input int i, input logic [127:0] pt, input logic [127:0] key);
    req_data[128*i +: 128] = pt;
    req_key[128*i +: 128]  = key;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  // Offer one FIPS job on requester i, then wait for its response.
  task automatic fips_job(input int i, input string tag);
    int hs0;
    hs0 = hs_cnt;
    set_slot(i, FIPS_PT, FIPS_KEY);
    req_valid = N'(1) << i;
    rsp_ready = 1'b1;
    cycle();
    req_valid = '0;
    for (int c = 0; c < 2 * L && hs_cnt == hs0; c++) cycle();
    check_eq({tag, "_hs"}, hs_cnt - hs0, 1);
    check_eq({tag, "_data"}, hs_data, FIPS_CT);
    check_eq({tag, "_id"}, hs_id, i);
    cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_data = '0; req_key = '0;
    rst1 = 1'b1; req_valid1 = '0; rsp_ready1 = 1'b0; req_data1 = '0; req_key1 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    req_valid = '1;
    cycle();                            // reset values, including req_ready held low
    req_valid = '0;
    rst = 1'b0;
    cycle();

    // Single job on requester 2: latency accept -> rsp_valid is CORE_LAT+2.
    obs_ids.delete(); obs_ts.delete();
    fips_job(2, "single");
    check_eq("single_grant", obs_ids.size() > 0 ? obs_ids[0] : -1, 2);
    check_eq("single_lat", obs_ts.size() > 0 ? hs_t - obs_ts[0] : -1, L + 2);

    // All requesters always valid, response taken immediately.
    do_reset();
    obs_ids.delete(); obs_ts.delete();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int c = 0; c < 100 && obs_ids.size() < 5; c++) begin
      for (int i = 0; i < N; i++) set_slot(i, rnd128(), rnd128());
      cycle();
    end
    check_eq("all_accepts", obs_ids.size(), 5);
    for (int i = 0; i < obs_ids.size() && i < 5; i++) begin
`ifdef AES_SCHED_RR_EN
      check_eq("all_grant", obs_ids[i], i % N);
`else
      check_eq("all_grant", obs_ids[i], 0);
`endif
      if (i > 0) check_eq("all_spacing", obs_ts[i] - obs_ts[i-1], L + 3);
    end
    req_valid = '0;
    for (int c = 0; c < 3 * L && m_busy; c++) cycle();

    // Response back-pressured for 20 cycles with every requester asking.
    begin
      int hs0;
      hs0 = hs_cnt;
      set_slot(1, FIPS_PT, FIPS_KEY);
      req_valid = 4'b0010;
      rsp_ready = 1'b0;
      cycle();
      req_valid = '1;
      for (int c = 0; c < 3 * L && !(m_busy && m_t >= m_acc + 2 + L); c++) cycle();
      for (int c = 0; c < 20; c++) cycle();
      check_eq("hold_no_hs", hs_cnt - hs0, 0);
      req_valid = '0;
      rsp_ready = 1'b1;
      cycle();
      check_eq("hold_hs", hs_cnt - hs0, 1);
      check_eq("hold_data", hs_data, FIPS_CT);
      check_eq("hold_id", hs_id, 1);
      cycle();
    end

    // Requester inputs overwritten right after accept.
    begin
      int hs0;
      hs0 = hs_cnt;
      set_slot(3, FIPS_PT, FIPS_KEY);
      req_valid = 4'b1000;
      cycle();
      req_valid = '0;
      req_data  = '1;
      req_key   = '1;
      for (int c = 0; c < 2 * L && hs_cnt == hs0; c++) cycle();
      check_eq("late_data", hs_data, FIPS_CT);
      check_eq("late_id", hs_id, 3);
      cycle();
    end

    // Reset during WAIT drops the job; a fresh job then completes.
    begin
      int hs0;
      hs0 = hs_cnt;
      set_slot(0, FIPS_PT, FIPS_KEY);
      req_valid = 4'b0001;
      cycle();
      req_valid = '0;
      for (int c = 0; c < 5; c++) cycle();
      do_reset();
      for (int c = 0; c < 20; c++) cycle();
      check_eq("rst_dropped", hs_cnt - hs0, 0);
      fips_job(0, "after_rst");
    end

    // Random traffic, back-pressure and occasional reset.
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 99) == 0);
      req_valid = ($urandom_range(0, 1) == 0) ? '0 : N'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
      for (int i = 0; i < N; i++) set_slot(i, rnd128(), rnd128());
      cycle();
    end
    rst = 1'b0;

    // One requester, unit core latency.
    @(posedge clk); #1;
    rst1 = 1'b0;
    req_valid1 = 1'b1; req_data1 = FIPS_PT; req_key1 = FIPS_KEY; rsp_ready1 = 1'b0;
    #1;
    check_eq("n1_ready_T", req_ready1, 1);
    check_eq("n1_start_T", core_start1, 0);
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    check_eq("n1_start_T1", core_start1, 1);
    check_eq("n1_busy_T1", busy1, 1);
    @(posedge clk); #1;
    check_eq("n1_start_T2", core_start1, 0);
    check_eq("n1_valid_T2", rsp_valid1, 0);
    @(posedge clk); #1;
    check_eq("n1_valid_T3", rsp_valid1, 1);
    check_eq("n1_data_T3", rsp_data1, FIPS_CT);
    check_eq("n1_id_T3", rsp_id1, 0);
    rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    check_eq("n1_valid_T4", rsp_valid1, 0);
    check_eq("n1_busy_T4", busy1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
